// File: rtl/fpu_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues word reads to a 1-cycle
// synchronous instruction memory, and buffers responses in a 2-entry queue.
module fpu_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] mem_address,
  input  logic [31:0] machine_code,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  fetch_entry_t [1:0] fifo;
  logic               rd_ptr, wr_ptr;
  logic [1:0]         count;
  logic [31:0]        pc, inflight_pc;
  logic               inflight_valid;
  logic               pop, issue, capture;
  logic [2:0]         occ;

  assign mem_address = pc;
  assign instr_valid = (count != 2'd0);
  assign instr_out   = fifo[rd_ptr].instr;
  assign instr_pc    = fifo[rd_ptr].pc;

  // Occupancy counts the in-flight read so a response always has a slot.
  assign pop     = instr_valid & instr_ready;
  assign occ     = {1'b0, count} + {2'b00, inflight_valid} - {2'b00, pop};
  assign issue   = !redirect_valid && (occ < 3'd2);
  assign capture = inflight_valid & !redirect_valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc             <= RESET_PC & WORD_MASK;
      inflight_valid <= 1'b0;
      inflight_pc    <= 32'h0;
      fifo           <= '0;
      rd_ptr         <= 1'b0;
      wr_ptr         <= 1'b0;
      count          <= 2'd0;
    end else if (redirect_valid) begin
      // A coinciding pop still completes; everything else is dropped.
      pc             <= redirect_pc & WORD_MASK;
      inflight_valid <= 1'b0;
      count          <= 2'd0;
      rd_ptr         <= wr_ptr;
    end else begin
      if (capture) begin
        fifo[wr_ptr] <= '{instr: machine_code, pc: inflight_pc};
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count          <= count + {1'b0, capture} - {1'b0, pop};
      inflight_valid <= issue;
      if (issue) begin
        inflight_pc <= pc;
        pc          <= pc + 32'd4;
      end
    end
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    !(capture && !pop && count == 2'd2));

endmodule

// File: tb/tb_fpu_fetch_unit.sv
// Directed bench for fpu_fetch_unit: per-cycle vector table covering startup,
// backpressure and redirects, plus PC wrap and asynchronous mid-stream reset.
module tb_fpu_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] mem_address, machine_code;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr_out, instr_pc;

  logic [31:0] mem_address2, machine_code2, instr_out2, instr_pc2;
  logic        instr_valid2;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  fpu_fetch_unit dut (
    .clock(clock), .reset(reset), .mem_address(mem_address),
    .machine_code(machine_code), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr_out(instr_out), .instr_pc(instr_pc)
  );

  fpu_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clock(clock), .reset(reset), .mem_address(mem_address2),
    .machine_code(machine_code2), .redirect_valid(1'b0),
    .redirect_pc(32'h0), .instr_valid(instr_valid2),
    .instr_ready(1'b1), .instr_out(instr_out2), .instr_pc(instr_pc2)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0013;
    if (a == 32'h4) return 32'h0020_81B3;
    return a ^ 32'h5A5A_0001;
  endfunction

  // Synchronous-read instruction memories
  always @(posedge clock) begin
    machine_code  <= mem_word(mem_address);
    machine_code2 <= mem_word(mem_address2);
  end

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
  } vec_t;

  vec_t vt [0:24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic setv(input int i, input logic rdy, input logic rv, input logic [31:0] rpc,
                      input logic ev, input logic [31:0] epc, input logic [31:0] eaddr);
    vt[i] = '{rdy: rdy, rv: rv, rpc: rpc, ev: ev, epc: epc, eaddr: eaddr};
  endtask

  // Row i: expected outputs during cycle i (cycle 0 starts at reset release)
  // and the inputs driven for that cycle.
  task automatic run_rows(input int lo, input int hi);
    logic [31:0] wpc;
    for (int i = lo; i <= hi; i++) begin
      if (i != lo) @(negedge clock);
      chk($sformatf("c%0d valid", i), {31'b0, instr_valid}, {31'b0, vt[i].ev});
      chk($sformatf("c%0d mem_address", i), mem_address, vt[i].eaddr);
      if (vt[i].ev) begin
        chk($sformatf("c%0d instr_pc", i), instr_pc, vt[i].epc);
        chk($sformatf("c%0d instr_out", i), instr_out, mem_word(vt[i].epc));
      end
      if (i >= 2 && i <= 5) begin
        wpc = 32'hFFFF_FFF8 + 32'(4 * (i - 2));
        chk($sformatf("wrap c%0d valid", i), {31'b0, instr_valid2}, 32'd1);
        chk($sformatf("wrap c%0d instr_pc", i), instr_pc2, wpc);
        chk($sformatf("wrap c%0d instr_out", i), instr_out2, mem_word(wpc));
      end
      instr_ready    = vt[i].rdy;
      redirect_valid = vt[i].rv;
      redirect_pc    = vt[i].rpc;
    end
  endtask

  initial begin
    //     i  rdy  rv   rpc           ev   epc    eaddr
    setv( 0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h00, 32'h00);
    setv( 1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h00, 32'h04);
    setv( 2, 1'b1, 1'b0, 32'h0,  1'b1, 32'h00, 32'h08);
    setv( 3, 1'b0, 1'b0, 32'h0,  1'b1, 32'h04, 32'h0C);
    setv( 4, 1'b0, 1'b0, 32'h0,  1'b1, 32'h04, 32'h0C);
    setv( 5, 1'b0, 1'b0, 32'h0,  1'b1, 32'h04, 32'h0C);
    setv( 6, 1'b0, 1'b0, 32'h0,  1'b1, 32'h04, 32'h0C);
    setv( 7, 1'b0, 1'b0, 32'h0,  1'b1, 32'h04, 32'h0C);
    setv( 8, 1'b1, 1'b0, 32'h0,  1'b1, 32'h04, 32'h0C);
    setv( 9, 1'b1, 1'b0, 32'h0,  1'b1, 32'h08, 32'h10);
    setv(10, 1'b1, 1'b0, 32'h0,  1'b1, 32'h0C, 32'h14);
    setv(11, 1'b1, 1'b0, 32'h0,  1'b1, 32'h10, 32'h18);
    setv(12, 1'b0, 1'b0, 32'h0,  1'b1, 32'h14, 32'h1C);
    setv(13, 1'b0, 1'b1, 32'h43, 1'b1, 32'h14, 32'h1C);
    setv(14, 1'b1, 1'b0, 32'h0,  1'b0, 32'h00, 32'h40);
    setv(15, 1'b1, 1'b0, 32'h0,  1'b0, 32'h00, 32'h44);
    setv(16, 1'b1, 1'b0, 32'h0,  1'b1, 32'h40, 32'h48);
    setv(17, 1'b1, 1'b0, 32'h0,  1'b1, 32'h44, 32'h4C);
    setv(18, 1'b1, 1'b1, 32'h10, 1'b1, 32'h48, 32'h50);
    setv(19, 1'b1, 1'b1, 32'h20, 1'b0, 32'h00, 32'h10);
    setv(20, 1'b1, 1'b0, 32'h0,  1'b0, 32'h00, 32'h20);
    setv(21, 1'b1, 1'b0, 32'h0,  1'b0, 32'h00, 32'h24);
    setv(22, 1'b1, 1'b0, 32'h0,  1'b1, 32'h20, 32'h28);
    setv(23, 1'b1, 1'b0, 32'h0,  1'b1, 32'h24, 32'h2C);
    setv(24, 1'b1, 1'b0, 32'h0,  1'b1, 32'h28, 32'h30);

    reset = 1'b1;
    instr_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    repeat (3) @(negedge clock);
    chk("reset valid", {31'b0, instr_valid}, 32'd0);
    chk("reset mem_address", mem_address, 32'h0);
    chk("reset instr_out", instr_out, 32'h0);
    chk("reset instr_pc", instr_pc, 32'h0);
    chk("reset wrap mem_address", mem_address2, 32'hFFFF_FFF8);
    reset = 1'b0;
    run_rows(0, 24);

    // Asynchronous reset mid-stream, checked before the next clock edge
    @(posedge clock);
    #2;
    chk("pre-reset valid", {31'b0, instr_valid}, 32'd1);
    reset = 1'b1;
    #1;
    chk("async reset valid", {31'b0, instr_valid}, 32'd0);
    chk("async reset mem_address", mem_address, 32'h0);
    chk("async reset instr_pc", instr_pc, 32'h0);
    chk("async reset instr_out", instr_out, 32'h0);
    @(negedge clock);
    @(negedge clock);
    instr_ready = 1'b1;
    redirect_valid = 1'b0;
    reset = 1'b0;
    run_rows(0, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
